// File: rtl/vector_load_unit.sv
// Vector/scalar load unit: fetches 1 or LANES words from memory and issues one register-file write.
// Optional build macro VLU_TIMEOUT_EN bounds each memory wait by TIMEOUT cycles and reports err.
module vector_load_unit #(
   parameter int LANES   = 16,
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int STRIDE  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                vec_mode,
   input  logic [AW-1:0]       base_addr,
   input  logic [3:0]          dest_reg,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                mem_req,
   output logic [AW-1:0]       mem_addr,
   input  logic                mem_valid,
   input  logic [DW-1:0]       mem_rdata,
   output logic                rf_we,
   output logic [3:0]          rf_wa,
   output logic                rf_wsel,
   output logic [LANES*DW-1:0] rf_wd
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_WRITE = 2'd3;

   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   logic [1:0]          state;
   logic                vec_r;
   logic [3:0]          dest_r;
   logic [AW-1:0]       addr_r;
   logic [LW-1:0]       lane_cnt;
   logic [LANES*DW-1:0] lane_buf;
   logic                last_word;
   logic                wait_expired;

   assign last_word = (lane_cnt == LAST_LANE);

`ifdef VLU_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [TW-1:0] wait_cnt;
   logic          err_r;

   // Fires in the TIMEOUT-th consecutive WAIT cycle without data.
   assign wait_expired = (state == S_WAIT) && !mem_valid && (wait_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         err_r    <= 1'b0;
      end else begin
         err_r <= wait_expired;
         if (state != S_WAIT)
            wait_cnt <= '0;
         else if (!mem_valid)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign err = err_r;
`else
   assign wait_expired = 1'b0;
   assign err          = 1'b0;
`endif

   // NOTE: state registers take non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         vec_r    <= 1'b0;
         dest_r   <= '0;
         addr_r   <= '0;
         lane_cnt <= '0;
         // NOTE: the lane buffer is reset too, so rf_wd reads 0 out of reset.
         lane_buf <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  vec_r    <= vec_mode;
                  dest_r   <= dest_reg;
                  addr_r   <= base_addr;
                  lane_buf <= '0;
                  lane_cnt <= vec_mode ? '0 : LAST_LANE;
                  state    <= S_REQ;
               end
            end
            S_REQ: state <= S_WAIT;
            S_WAIT: begin
               if (mem_valid) begin
                  for (int i = 0; i < LANES; i++) begin
                     if (lane_cnt == LW'(i))
                        lane_buf[i*DW +: DW] <= mem_rdata;
                  end
                  if (last_word) begin
                     state <= S_WRITE;
                  end else begin
                     lane_cnt <= lane_cnt + 1'b1;
                     addr_r   <= addr_r + AW'(STRIDE);
                     state    <= S_REQ;
                  end
               end else if (wait_expired) begin
                  state <= S_IDLE;
               end
            end
            S_WRITE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write-side outputs come straight from registers, so they hold steady through WRITE.
   assign busy     = (state != S_IDLE);
   assign mem_req  = (state == S_REQ);
   assign mem_addr = addr_r;
   assign rf_we    = (state == S_WRITE);
   assign done     = rf_we;
   assign rf_wa    = dest_r;
   assign rf_wsel  = vec_r;
   assign rf_wd    = lane_buf;

endmodule

// File: tb/tb_vector_load_unit.sv
// Scoreboard bench for vector_load_unit: a memory responder and a write monitor pop expectations
// that each test task pushes when it issues a load.
module tb_vector_load_unit;

   localparam int LANES  = 16;
   localparam int DW     = 32;
   localparam int AW     = 32;
   localparam int STRIDE = 4;
`ifdef VLU_TIMEOUT_EN
   localparam int TIMEOUT = 8;
`else
   localparam int TIMEOUT = 255;
`endif

   logic                clk;
   logic                rst;
   logic                start;
   logic                vec_mode;
   logic [AW-1:0]       base_addr;
   logic [3:0]          dest_reg;
   logic                busy;
   logic                done;
   logic                err;
   logic                mem_req;
   logic [AW-1:0]       mem_addr;
   logic                mem_valid;
   logic [DW-1:0]       mem_rdata;
   logic                rf_we;
   logic [3:0]          rf_wa;
   logic                rf_wsel;
   logic [LANES*DW-1:0] rf_wd;

   vector_load_unit #(
      .LANES(LANES), .DW(DW), .AW(AW), .STRIDE(STRIDE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .vec_mode(vec_mode), .base_addr(base_addr),
      .dest_reg(dest_reg), .busy(busy), .done(done), .err(err), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .rf_we(rf_we),
      .rf_wa(rf_wa), .rf_wsel(rf_wsel), .rf_wd(rf_wd)
   );

   typedef struct {
      logic [3:0]          wa;
      logic                wsel;
      logic [LANES*DW-1:0] wd;
   } wr_t;

   wr_t         wr_q[$];
   logic [AW-1:0] addr_q[$];

   int checks = 0;
   int errors = 0;
   int cycle_cnt = 0;
   int write_count = 0;
   int req_count = 0;
   int err_count = 0;
   int last_write_cycle = 0;
   int last_req_cycle = 0;
   int last_err_cycle = 0;
   int start_cycle = 0;

   // Memory responder knobs
   bit            pending = 0;
   int            wcnt = 0;
   logic [AW-1:0] req_addr = '0;
   int            wait_fixed = 0;
   bit            wait_rand = 0;
   bit            spurious_en = 0;
   bit            fixed_en = 0;
   logic [DW-1:0] fixed_data = '0;
   bit            hold_en = 0;
   logic [AW-1:0] hold_addr = '0;
   int            hold_wait = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   function automatic logic [LANES*DW-1:0] model_bundle(input bit vec, input logic [AW-1:0] base);
      logic [LANES*DW-1:0] b;
      logic [AW-1:0]       a;
      b = '0;
      if (vec) begin
         for (int i = 0; i < LANES; i++) begin
            a = base + AW'(i * STRIDE);
            b[i*DW +: DW] = DW'(a >> 2);
         end
      end else begin
         b[(LANES-1)*DW +: DW] = fixed_en ? fixed_data : DW'(base >> 2);
      end
      return b;
   endfunction

   // Memory: answers each mem_req after the chosen wait, sprinkles junk valids when idle.
   initial begin
      mem_valid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_valid = 1'b0;
         mem_rdata = $urandom;
         if (pending) begin
            if (wcnt == 0) begin
               mem_valid = 1'b1;
               mem_rdata = fixed_en ? fixed_data : DW'(req_addr >> 2);
               pending   = 0;
            end else begin
               wcnt--;
            end
         end else if (spurious_en && $urandom_range(0, 2) == 0) begin
            mem_valid = 1'b1;
         end
         if (mem_req === 1'b1) begin
            req_count++;
            last_req_cycle = cycle_cnt;
            checks++;
            if (addr_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_mem_req: mem_addr=%h, none required", mem_addr);
            end else begin
               logic [AW-1:0] ea;
               ea = addr_q.pop_front();
               if (mem_addr !== ea) begin
                  errors++;
                  $display("FAIL mem_addr: got %h, required %h", mem_addr, ea);
               end
            end
            pending  = 1;
            req_addr = mem_addr;
            if (hold_en && mem_addr == hold_addr) wcnt = hold_wait;
            else if (wait_rand)                    wcnt = $urandom_range(0, 5);
            else                                   wcnt = wait_fixed;
         end
      end
   end

   // Write monitor: each rf_we pops one expected write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rf_we === 1'b1 || done === 1'b1) begin
            checks++;
            if (done !== rf_we) begin
               errors++;
               $display("FAIL done_with_we: done=%b rf_we=%b, required equal", done, rf_we);
            end
            if (rf_we === 1'b1) begin
               write_count++;
               last_write_cycle = cycle_cnt;
               checks++;
               if (wr_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write: rf_wa=%0d rf_wsel=%b, none required", rf_wa, rf_wsel);
               end else begin
                  e = wr_q.pop_front();
                  if (rf_wa !== e.wa || rf_wsel !== e.wsel || rf_wd !== e.wd) begin
                     errors++;
                     $display("FAIL rf_write: got wa=%0d wsel=%b wd=%h, required wa=%0d wsel=%b wd=%h",
                              rf_wa, rf_wsel, rf_wd, e.wa, e.wsel, e.wd);
                  end
               end
            end
         end
         if (err === 1'b1) begin
            err_count++;
            last_err_cycle = cycle_cnt;
         end
      end
   end

   task automatic push_expect(input bit vec, input logic [AW-1:0] base, input logic [3:0] dest,
                              input int n_addr, input bit with_write);
      wr_t e;
      for (int i = 0; i < n_addr; i++) addr_q.push_back(base + AW'(i * STRIDE));
      if (with_write) begin
         e.wa   = dest;
         e.wsel = vec;
         e.wd   = model_bundle(vec, base);
         wr_q.push_back(e);
      end
   endtask

   task automatic do_start(input bit vec, input logic [AW-1:0] base, input logic [3:0] dest);
      @(negedge clk); #1;
      start       = 1'b1;
      vec_mode    = vec;
      base_addr   = base;
      dest_reg    = dest;
      start_cycle = cycle_cnt;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_write(input int budget);
      int w0;
      bit seen;
      w0   = write_count;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk); #1;
         if (write_count != w0) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL write_timeout: no rf_we within %0d cycles", budget);
      end
   endtask

   task automatic flush();
      wr_q.delete();
      addr_q.delete();
      pending = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({busy, done, err, mem_req, rf_we, rf_wsel} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy/done/err/req/we/wsel=%b, required 000000",
                  {busy, done, err, mem_req, rf_we, rf_wsel});
      end
      checks++;
      if (mem_addr !== '0 || rf_wa !== '0) begin
         errors++;
         $display("FAIL reset_addr: mem_addr=%h rf_wa=%0d, required 0", mem_addr, rf_wa);
      end
      checks++;
      if (rf_wd !== '0) begin
         errors++;
         $display("FAIL reset_wd: rf_wd=%h, required 0", rf_wd);
      end
      rst = 1'b0;
   endtask

   task automatic test_scalar();
      int r0, w0;
      r0 = req_count; w0 = write_count;
      fixed_en = 1; fixed_data = 32'hDEADBEEF; wait_fixed = 2;
      push_expect(0, 32'h100, 4'd3, 1, 1);
      do_start(0, 32'h100, 4'd3);
      wait_write(50);
      checks++;
      if (last_write_cycle - start_cycle != 5) begin
         errors++;
         $display("FAIL scalar_latency: got %0d, required 5", last_write_cycle - start_cycle);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (req_count - r0 != 1 || write_count - w0 != 1) begin
         errors++;
         $display("FAIL scalar_counts: reqs=%0d writes=%0d, required 1 and 1", req_count - r0, write_count - w0);
      end
      fixed_en = 0; wait_fixed = 0;
   endtask

   task automatic test_vector();
      int r0;
      r0 = req_count;
      push_expect(1, 32'h200, 4'd2, LANES, 1);
      do_start(1, 32'h200, 4'd2);
      wait_write(100);
      checks++;
      if (last_write_cycle - start_cycle != 2 * LANES + 1) begin
         errors++;
         $display("FAIL vector_latency: got %0d, required %0d", last_write_cycle - start_cycle, 2 * LANES + 1);
      end
      checks++;
      if (req_count - r0 != LANES) begin
         errors++;
         $display("FAIL vector_reqs: got %0d, required %0d", req_count - r0, LANES);
      end
   endtask

   task automatic test_random();
      int r0, w0;
      r0 = req_count; w0 = write_count;
      wait_rand = 1; spurious_en = 1;
      push_expect(1, 32'h3000, 4'd9, LANES, 1);
      do_start(1, 32'h3000, 4'd9);
      for (int k = 0; k < 3; k++) begin
         repeat (5) @(negedge clk);
         do_start(0, 32'h999 + AW'(k), 4'd5);
      end
      wait_write(300);
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (write_count - w0 != 1) begin
         errors++;
         $display("FAIL random_writes: got %0d, required 1", write_count - w0);
      end
      checks++;
      if (req_count - r0 != LANES) begin
         errors++;
         $display("FAIL random_reqs: got %0d, required %0d", req_count - r0, LANES);
      end
      wait_rand = 0; spurious_en = 0;
   endtask

   task automatic test_wrap_and_reset();
      int  r0, w0;
      bit  hit;
      r0 = req_count;
      push_expect(1, 32'hFFFF_FFF8, 4'd1, LANES, 1);
      do_start(1, 32'hFFFF_FFF8, 4'd1);
      wait_write(100);
      checks++;
      if (req_count - r0 != LANES) begin
         errors++;
         $display("FAIL wrap_reqs: got %0d, required %0d", req_count - r0, LANES);
      end
      // Second run: reset while lane 7 is waiting on memory.
      r0 = req_count; w0 = write_count; wait_fixed = 20; hit = 0;
      push_expect(1, 32'h500, 4'd7, LANES, 0);
      do_start(1, 32'h500, 4'd7);
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk); #1;
         if (req_count - r0 == 8) hit = 1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL lane7_req_timeout: reqs=%0d, required 8", req_count - r0);
      end
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || rf_we !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_in_wait: busy=%b rf_we=%b mem_req=%b, required 0", busy, rf_we, mem_req);
      end
      @(negedge clk); #1;
      checks++;
      if (rf_wd !== '0 || err !== 1'b0) begin
         errors++;
         $display("FAIL rst_held: rf_wd=%h err=%b, required 0", rf_wd, err);
      end
      // rst and start together: reset must win.
      start = 1'b1; vec_mode = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_beats_start: busy=%b, required 0", busy);
      end
      rst = 1'b0;
      flush();
      wait_fixed = 0;
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (write_count != w0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_write: writes=%0d busy=%b, required 0 and 0", write_count - w0, busy);
      end
   endtask

   task automatic test_back_to_back();
      int w0;
      w0 = write_count;
      push_expect(0, 32'h600, 4'd4, 1, 1);
      do_start(0, 32'h600, 4'd4);
      wait_write(20);
      push_expect(0, 32'h604, 4'd5, 1, 1);
      do_start(0, 32'h604, 4'd5);
      wait_write(20);
      checks++;
      if (last_write_cycle - start_cycle != 3) begin
         errors++;
         $display("FAIL b2b_latency: got %0d, required 3", last_write_cycle - start_cycle);
      end
      checks++;
      if (write_count - w0 != 2) begin
         errors++;
         $display("FAIL b2b_writes: got %0d, required 2", write_count - w0);
      end
   endtask

`ifdef VLU_TIMEOUT_EN
   task automatic test_timeout();
      int  e0, w0, req4;
      bit  seen;
      e0 = err_count; w0 = write_count; seen = 0;
      hold_en = 1; hold_addr = 32'h700 + AW'(4 * STRIDE); hold_wait = TIMEOUT + 3;
      push_expect(1, 32'h700, 4'd6, 5, 0);
      do_start(1, 32'h700, 4'd6);
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk); #1;
         if (err_count != e0) seen = 1;
      end
      req4 = last_req_cycle;
      checks++;
      if (!seen || last_err_cycle - req4 != TIMEOUT + 1) begin
         errors++;
         $display("FAIL timeout_err: seen=%0d delay=%0d, required 1 and %0d", seen, last_err_cycle - req4, TIMEOUT + 1);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: busy=%b, required 0", busy);
      end
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (write_count != w0 || err_count - e0 != 1) begin
         errors++;
         $display("FAIL timeout_after: writes=%0d errs=%0d, required 0 and 1", write_count - w0, err_count - e0);
      end
      hold_en = 0;
      flush();
      push_expect(1, 32'h800, 4'd8, LANES, 1);
      do_start(1, 32'h800, 4'd8);
      wait_write(100);
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; vec_mode = 1'b0; base_addr = '0; dest_reg = '0;
      test_reset();
      test_scalar();
      test_vector();
      test_random();
      test_wrap_and_reset();
      test_back_to_back();
`ifdef VLU_TIMEOUT_EN
      test_timeout();
`else
      checks++;
      if (err_count != 0) begin
         errors++;
         $display("FAIL err_tied_low: pulses=%0d, required 0", err_count);
      end
`endif
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (wr_q.size() != 0 || addr_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expect: writes=%0d addrs=%0d, required 0", wr_q.size(), addr_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
